// File: rtl/addr_map_rule_pkg.sv
// Address-map rule entry shared by crossbar decoders.
package addr_map_rule_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

endpackage

// File: rtl/sap_pkg.sv
// SAP crossbar constants: boot address map and decoder register layout.
package sap_pkg;
  import addr_map_rule_pkg::*;

  localparam int unsigned SAP_NUM_RULES = 5;

  // Register layout, also consumed by the software header generator.
  localparam logic [7:0] RULE_STRIDE    = 8'h10;
  localparam logic [7:0] RULE_START_OFS = 8'h00;
  localparam logic [7:0] RULE_END_OFS   = 8'h04;
  localparam logic [7:0] RULE_CFG_OFS   = 8'h08;
  localparam logic [7:0] CTRL_OFS       = 8'hF0;
  localparam logic [7:0] STATUS_OFS     = 8'hF4;

  localparam int unsigned CFG_ENABLE_BIT       = 31;
  localparam int unsigned CTRL_COMMIT_BIT      = 0;
  localparam int unsigned CTRL_LOCK_BIT        = 1;
  localparam int unsigned STATUS_PENDING_BIT   = 0;
  localparam int unsigned STATUS_LOCKED_BIT    = 1;
  localparam int unsigned STATUS_CFG_ERROR_BIT = 2;

  // Boot map; end addresses are exclusive.
  localparam addr_map_rule_t [SAP_NUM_RULES-1:0] XBAR_ADDR_RULES = '{
    0: '{idx: 32'd0, start_addr: 32'h1A00_0000, end_addr: 32'h1A01_0000},
    1: '{idx: 32'd1, start_addr: 32'h1901_0000, end_addr: 32'h1902_0000},
    2: '{idx: 32'd2, start_addr: 32'h1900_0000, end_addr: 32'h1901_0000},
    3: '{idx: 32'd3, start_addr: 32'h1902_0000, end_addr: 32'h1902_8000},
    4: '{idx: 32'd4, start_addr: 32'h1902_8000, end_addr: 32'h1903_0000}
  };

endpackage

// File: rtl/sap_addr_rule_match.sv
// Combinational priority matcher: lowest-numbered enabled rule containing addr wins.
module sap_addr_rule_match
  import addr_map_rule_pkg::*;
#(
  parameter int unsigned          NUM_RULES   = 5,
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter int unsigned          IDX_WIDTH   = 3,
  parameter logic [IDX_WIDTH-1:0] DEFAULT_IDX = '0
) (
  input  addr_map_rule_t [NUM_RULES-1:0] rules,
  input  logic [NUM_RULES-1:0]           en,
  input  logic [ADDR_WIDTH-1:0]          addr,
  output logic [IDX_WIDTH-1:0]           idx,
  output logic                           hit
);

  // Scan from the top down so the lowest matching rule is the one left standing.
  // A rule whose idx would be truncated by the output width is never routed.
  always_comb begin
    idx = DEFAULT_IDX;
    hit = 1'b0;
    for (int i = int'(NUM_RULES) - 1; i >= 0; i--) begin
      if (en[i] &&
          ((rules[i].idx >> IDX_WIDTH) == '0) &&
          (addr >= rules[i].start_addr[ADDR_WIDTH-1:0]) &&
          (addr <  rules[i].end_addr[ADDR_WIDTH-1:0])) begin
        idx = rules[i].idx[IDX_WIDTH-1:0];
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sap_addr_decoder_cfg.sv
// Runtime-programmable crossbar address decoder with shadow/active tables,
// atomic commit, sticky lock and a one-cycle registered lookup pipeline.
module sap_addr_decoder_cfg
  import addr_map_rule_pkg::*;
  import sap_pkg::*;
#(
  parameter int unsigned                    NUM_RULES   = 5,
  parameter int unsigned                    ADDR_WIDTH  = 32,
  parameter int unsigned                    IDX_WIDTH   = 3,
  parameter logic [IDX_WIDTH-1:0]           DEFAULT_IDX = '0,
  parameter addr_map_rule_t [NUM_RULES-1:0] RESET_RULES = XBAR_ADDR_RULES
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  reg_req_i,
  input  logic                  reg_we_i,
  input  logic [7:0]            reg_addr_i,
  input  logic [31:0]           reg_wdata_i,
  output logic                  reg_gnt_o,
  output logic                  reg_rvalid_o,
  output logic [31:0]           reg_rdata_o,
  output logic                  reg_err_o,
  input  logic                  lkp_valid_i,
  input  logic [ADDR_WIDTH-1:0] lkp_addr_i,
  output logic                  lkp_valid_o,
  output logic [IDX_WIDTH-1:0]  lkp_idx_o,
  output logic                  lkp_hit_o,
  output logic                  locked_o
);

  addr_map_rule_t [NUM_RULES-1:0] shadow_q, active_q;
  logic [NUM_RULES-1:0]           shadow_en_q, active_en_q;
  logic                           locked_q, cfg_error_q;

  logic [NUM_RULES-1:0] rule_sel;
  logic                 sel_start, sel_end, sel_cfg, sel_ctrl, sel_status;
  logic                 rule_mapped, pending, cfg_valid;
  logic                 rule_wr, do_commit, do_lock;
  logic                 rsp_err;
  logic [31:0]          rsp_rdata;
  logic [IDX_WIDTH-1:0] match_idx;
  logic                 match_hit;

  assign reg_gnt_o = reg_req_i;
  assign locked_o  = locked_q;
  assign pending   = (shadow_q != active_q) || (shadow_en_q != active_en_q);

  // Offset decode; misaligned offsets select nothing and fall through to an error.
  always_comb begin
    for (int i = 0; i < int'(NUM_RULES); i++) begin
      rule_sel[i] = (reg_addr_i[1:0] == 2'b00) && (reg_addr_i[7:4] == 4'(i));
    end
    sel_start   = reg_addr_i[3:0] == RULE_START_OFS[3:0];
    sel_end     = reg_addr_i[3:0] == RULE_END_OFS[3:0];
    sel_cfg     = reg_addr_i[3:0] == RULE_CFG_OFS[3:0];
    sel_ctrl    = reg_addr_i == CTRL_OFS;
    sel_status  = reg_addr_i == STATUS_OFS;
    rule_mapped = (|rule_sel) && (sel_start || sel_end || sel_cfg);
  end

  // Access classification: read data, error flag and the write side effects.
  always_comb begin
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    rule_wr   = 1'b0;
    do_commit = 1'b0;
    do_lock   = 1'b0;
    if (rule_mapped) begin
      if (reg_we_i) begin
        if (locked_q) rsp_err = 1'b1;
        else          rule_wr = 1'b1;
      end else begin
        for (int i = 0; i < int'(NUM_RULES); i++) begin
          if (rule_sel[i]) begin
            if (sel_start)    rsp_rdata = shadow_q[i].start_addr;
            else if (sel_end) rsp_rdata = shadow_q[i].end_addr;
            else rsp_rdata = {shadow_en_q[i], {(31-IDX_WIDTH){1'b0}},
                              shadow_q[i].idx[IDX_WIDTH-1:0]};
          end
        end
      end
    end else if (sel_ctrl) begin
      if (reg_we_i) begin
        // Once locked, only a bare re-assertion of LOCK is accepted.
        if (locked_q && !(reg_wdata_i[CTRL_LOCK_BIT] && !reg_wdata_i[CTRL_COMMIT_BIT])) begin
          rsp_err = 1'b1;
        end else begin
          do_commit = reg_wdata_i[CTRL_COMMIT_BIT];
          do_lock   = reg_wdata_i[CTRL_LOCK_BIT];
        end
      end else begin
        rsp_rdata[CTRL_LOCK_BIT] = locked_q;
      end
    end else if (sel_status) begin
      if (reg_we_i) begin
        rsp_err = 1'b1;
      end else begin
        rsp_rdata[STATUS_PENDING_BIT]   = pending;
        rsp_rdata[STATUS_LOCKED_BIT]    = locked_q;
        rsp_rdata[STATUS_CFG_ERROR_BIT] = cfg_error_q;
      end
    end else begin
      rsp_err = 1'b1;
    end
  end

  // Shadow table must be self-consistent before it may become active.
  always_comb begin
    cfg_valid = 1'b1;
    for (int i = 0; i < int'(NUM_RULES); i++) begin
      if (shadow_en_q[i] &&
          (!(shadow_q[i].start_addr[ADDR_WIDTH-1:0] < shadow_q[i].end_addr[ADDR_WIDTH-1:0]) ||
           (shadow_q[i].idx >= NUM_RULES))) begin
        cfg_valid = 1'b0;
      end
    end
  end

  // Shadow table: software-visible rule storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q    <= RESET_RULES;
      shadow_en_q <= '1;
    end else if (reg_req_i && rule_wr) begin
      for (int i = 0; i < int'(NUM_RULES); i++) begin
        if (rule_sel[i]) begin
          if (sel_start) shadow_q[i].start_addr <= reg_wdata_i;
          if (sel_end)   shadow_q[i].end_addr   <= reg_wdata_i;
          if (sel_cfg) begin
            shadow_q[i].idx <= {{(32-IDX_WIDTH){1'b0}}, reg_wdata_i[IDX_WIDTH-1:0]};
            shadow_en_q[i]  <= reg_wdata_i[CFG_ENABLE_BIT];
          end
        end
      end
    end
  end

  // Active table, validation result and lock; commit and lock may share one write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q    <= RESET_RULES;
      active_en_q <= '1;
      cfg_error_q <= 1'b0;
      locked_q    <= 1'b0;
    end else if (reg_req_i) begin
      if (do_commit) begin
        if (cfg_valid) begin
          active_q    <= shadow_q;
          active_en_q <= shadow_en_q;
          cfg_error_q <= 1'b0;
        end else begin
          cfg_error_q <= 1'b1;
        end
      end
      if (do_lock) locked_q <= 1'b1;
    end
  end

  // Register response, one cycle after each grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= '0;
      reg_err_o    <= 1'b0;
    end else begin
      reg_rvalid_o <= reg_req_i;
      if (reg_req_i) begin
        reg_rdata_o <= rsp_rdata;
        reg_err_o   <= rsp_err;
      end
    end
  end

  sap_addr_rule_match #(
    .NUM_RULES  (NUM_RULES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH),
    .DEFAULT_IDX(DEFAULT_IDX)
  ) u_match (
    .rules(active_q),
    .en   (active_en_q),
    .addr (lkp_addr_i),
    .idx  (match_idx),
    .hit  (match_hit)
  );

  // Lookup pipeline register; idx/hit hold while no lookup is presented.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lkp_valid_o <= 1'b0;
      lkp_idx_o   <= DEFAULT_IDX;
      lkp_hit_o   <= 1'b0;
    end else begin
      lkp_valid_o <= lkp_valid_i;
      if (lkp_valid_i) begin
        lkp_idx_o <= match_idx;
        lkp_hit_o <= match_hit;
      end
    end
  end

endmodule

// File: tb/tb_sap_addr_decoder_cfg.sv
// Directed bench for sap_addr_decoder_cfg against the boot map in sap_pkg.
module tb_sap_addr_decoder_cfg;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        reg_req = 1'b0, reg_we = 1'b0;
  logic [7:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic        reg_gnt, reg_rvalid, reg_err;
  logic [31:0] reg_rdata;
  logic        lkp_valid = 1'b0;
  logic [31:0] lkp_addr = '0;
  logic        lkp_valid_q, lkp_hit, locked;
  logic [2:0]  lkp_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  sap_addr_decoder_cfg dut (
    .clk_i       (clk_sys),
    .rst_ni      (rst_n),
    .reg_req_i   (reg_req),
    .reg_we_i    (reg_we),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_gnt_o   (reg_gnt),
    .reg_rvalid_o(reg_rvalid),
    .reg_rdata_o (reg_rdata),
    .reg_err_o   (reg_err),
    .lkp_valid_i (lkp_valid),
    .lkp_addr_i  (lkp_addr),
    .lkp_valid_o (lkp_valid_q),
    .lkp_idx_o   (lkp_idx),
    .lkp_hit_o   (lkp_hit),
    .locked_o    (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the response and one idle cycle.
  task automatic reg_xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err);
    reg_req = 1'b1; reg_we = we; reg_addr = a; reg_wdata = d;
    #1 chk("gnt", reg_gnt, 1);
    @(posedge clk_sys); #1;
    reg_req = 1'b0; reg_we = 1'b0;
    chk("rvalid", reg_rvalid, 1);
    rd = reg_rdata; err = reg_err;
    @(posedge clk_sys); #1;
    chk("rvalid_pulse", reg_rvalid, 0);
  endtask

  task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d, input logic exp_err);
    logic [31:0] rd; logic err;
    reg_xfer(1'b1, a, d, rd, err);
    chk({tag, "_err"}, err, exp_err);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp_d, input logic exp_err);
    logic [31:0] d; logic err;
    reg_xfer(1'b0, a, 32'h0, d, err);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_data"}, d, exp_d);
  endtask

  task automatic lk(input string tag, input logic [31:0] a, input logic [2:0] exp_idx, input logic exp_hit);
    lkp_valid = 1'b1; lkp_addr = a;
    @(posedge clk_sys); #1;
    lkp_valid = 1'b0;
    chk({tag, "_valid"}, lkp_valid_q, 1);
    chk({tag, "_idx"}, lkp_idx, exp_idx);
    chk({tag, "_hit"}, lkp_hit, exp_hit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk_sys); @(posedge clk_sys); #1;
    chk("rst_lkp_valid", lkp_valid_q, 0);
    chk("rst_lkp_idx", lkp_idx, 0);
    chk("rst_lkp_hit", lkp_hit, 0);
    chk("rst_locked", locked, 0);
    chk("rst_rvalid", reg_rvalid, 0);
    chk("rst_rdata", reg_rdata, 0);
    chk("rst_rerr", reg_err, 0);
    @(negedge clk_sys) rst_n = 1'b1;
    @(posedge clk_sys); #1;

    // 1: boot map
    lk("t1_r3", 32'h1902_0010, 3'd3, 1'b1);
    lk("t1_miss", 32'h0000_0000, 3'd0, 1'b0);
    lk("t1_end_excl", 32'h1902_8000, 3'd4, 1'b1);
    lk("t1_last_in", 32'h1902_7FFF, 3'd3, 1'b1);
    rd("t1_status", 8'hF4, 32'h0, 1'b0);
    rd("t1_cfg3", 8'h38, 32'h8000_0003, 1'b0);
    rd("t1_hole", 8'h0C, 32'h0, 1'b1);

    // 2: shadow edit, then commit
    wr("t2_s3", 8'h30, 32'h1903_0000, 1'b0);
    wr("t2_e3", 8'h34, 32'h1903_1000, 1'b0);
    lk("t2_pre", 32'h1903_0004, 3'd0, 1'b0);
    rd("t2_pending", 8'hF4, 32'h1, 1'b0);
    rd("t2_shadow_rd", 8'h30, 32'h1903_0000, 1'b0);
    wr("t2_commit", 8'hF0, 32'h1, 1'b0);
    lk("t2_post", 32'h1903_0004, 3'd3, 1'b1);
    rd("t2_status", 8'hF4, 32'h0, 1'b0);

    // 3: validation failures
    wr("t3_s1", 8'h10, 32'h1901_1000, 1'b0);
    wr("t3_e1", 8'h14, 32'h1901_1000, 1'b0);
    wr("t3_commit_bad", 8'hF0, 32'h1, 1'b0);
    rd("t3_status_bad", 8'hF4, 32'h5, 1'b0);
    lk("t3_old_map", 32'h1901_0000, 3'd1, 1'b1);
    wr("t3_e1_fix", 8'h14, 32'h1901_2000, 1'b0);
    wr("t3_commit_ok", 8'hF0, 32'h1, 1'b0);
    rd("t3_status_ok", 8'hF4, 32'h0, 1'b0);
    lk("t3_new_in", 32'h1901_1800, 3'd1, 1'b1);
    lk("t3_new_out", 32'h1901_0000, 3'd0, 1'b0);
    wr("t3_cfg0_bad", 8'h08, 32'h8000_0006, 1'b0);
    rd("t3_cfg0_rd", 8'h08, 32'h8000_0006, 1'b0);
    wr("t3_commit_idx", 8'hF0, 32'h1, 1'b0);
    rd("t3_status_idx", 8'hF4, 32'h5, 1'b0);
    wr("t3_cfg0_fix", 8'h08, 32'h8000_0000, 1'b0);
    rd("t3_status_nopend", 8'hF4, 32'h4, 1'b0);
    wr("t3_commit_idx_ok", 8'hF0, 32'h1, 1'b0);
    rd("t3_status_idx_ok", 8'hF4, 32'h0, 1'b0);

    // 4: overlap priority and enable
    wr("t4_s1", 8'h10, 32'h1902_0000, 1'b0);
    wr("t4_e1", 8'h14, 32'h1902_1000, 1'b0);
    wr("t4_s3", 8'h30, 32'h1902_0000, 1'b0);
    wr("t4_e3", 8'h34, 32'h1902_8000, 1'b0);
    wr("t4_commit", 8'hF0, 32'h1, 1'b0);
    lk("t4_prio", 32'h1902_0000, 3'd1, 1'b1);
    wr("t4_dis1", 8'h18, 32'h0000_0001, 1'b0);
    rd("t4_cfg1_rd", 8'h18, 32'h0000_0001, 1'b0);
    wr("t4_commit2", 8'hF0, 32'h1, 1'b0);
    lk("t4_fallthru", 32'h1902_0000, 3'd3, 1'b1);

    // 5: lock, then asynchronous reset mid-burst
    wr("t5_lock", 8'hF0, 32'h2, 1'b0);
    chk("t5_locked", locked, 1);
    rd("t5_status", 8'hF4, 32'h2, 1'b0);
    wr("t5_locked_wr", 8'h30, 32'h1234_5678, 1'b1);
    rd("t5_readback", 8'h30, 32'h1902_0000, 1'b0);
    wr("t5_commit_locked", 8'hF0, 32'h1, 1'b1);
    wr("t5_relock", 8'hF0, 32'h2, 1'b0);
    wr("t5_status_wr", 8'hF4, 32'h0, 1'b1);
    rd("t5_status2", 8'hF4, 32'h2, 1'b0);
    lkp_valid = 1'b1; lkp_addr = 32'h1902_8000;
    @(posedge clk_sys); #1;
    chk("t5_burst_idx", lkp_idx, 4);
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = 8'hF4;
    @(posedge clk_sys); #1;
    reg_req = 1'b0;
    chk("t5_inflight", reg_rvalid, 1);
    chk("t5_burst_valid", lkp_valid_q, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_rvalid", reg_rvalid, 0);
    chk("t5_rst_rdata", reg_rdata, 0);
    chk("t5_rst_lkp_valid", lkp_valid_q, 0);
    chk("t5_rst_lkp_idx", lkp_idx, 0);
    chk("t5_rst_lkp_hit", lkp_hit, 0);
    chk("t5_rst_locked", locked, 0);
    lkp_valid = 1'b0;
    @(negedge clk_sys) rst_n = 1'b1;
    @(posedge clk_sys); #1;
    lk("t5_boot_map", 32'h1901_0000, 3'd1, 1'b1);
    rd("t5_status_rst", 8'hF4, 32'h0, 1'b0);

    // 6: commit lands inside a stream of lookups
    wr("t6_s3", 8'h30, 32'h1904_0000, 1'b0);
    wr("t6_e3", 8'h34, 32'h1904_1000, 1'b0);
    lkp_valid = 1'b1; lkp_addr = 32'h1904_0100;
    @(posedge clk_sys); #1;
    chk("t6_c0_idx", lkp_idx, 0);
    chk("t6_c0_hit", lkp_hit, 0);
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'hF0; reg_wdata = 32'h1;
    @(posedge clk_sys); #1;
    reg_req = 1'b0; reg_we = 1'b0;
    chk("t6_commit_rvalid", reg_rvalid, 1);
    chk("t6_commit_err", reg_err, 0);
    chk("t6_c1_valid", lkp_valid_q, 1);
    chk("t6_c1_old_hit", lkp_hit, 0);
    @(posedge clk_sys); #1;
    chk("t6_c2_valid", lkp_valid_q, 1);
    chk("t6_c2_new_idx", lkp_idx, 3);
    chk("t6_c2_new_hit", lkp_hit, 1);
    lkp_addr = 32'h1901_0004;
    @(posedge clk_sys); #1;
    chk("t6_c3_valid", lkp_valid_q, 1);
    chk("t6_c3_idx", lkp_idx, 1);
    lkp_valid = 1'b0;
    @(posedge clk_sys); #1;
    chk("t6_idle_valid", lkp_valid_q, 0);
    chk("t6_idle_hold_idx", lkp_idx, 1);
    chk("t6_idle_hold_hit", lkp_hit, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
